// File: rtl/lsu_mc.sv
// rtl/lsu_mc.sv - multi-cycle load/store unit with a handshaked data-memory port
module lsu_mc #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_store,
    input  logic [2:0]          in_funct3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    input  logic                mem_rsp_err,
    output logic                out_valid,
    output logic [XLEN-1:0]     out_rdata,
    output logic                out_misalign,
    output logic                out_buserr
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TO_V = (CNT_W + 1)'(TIMEOUT);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]        state;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic              mis_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    cnt_nxt;

    logic [OFF_W-1:0]  in_off;
    logic [7:0]        size_mask8;
    logic [NB-1:0]     in_wstrb;
    logic              bad;

    // Decode of the incoming op: lane offset, byte mask and fault detection
    always_comb begin
        in_off = in_addr[OFF_W-1:0];
        case (in_funct3[1:0])
            2'b00:   size_mask8 = 8'h01;
            2'b01:   size_mask8 = 8'h03;
            2'b10:   size_mask8 = 8'h0F;
            default: size_mask8 = 8'hFF;
        endcase
        in_wstrb = size_mask8[NB-1:0] << in_off;
        bad = (in_funct3 == 3'b111)
            || ((XLEN == 32) && (in_funct3 == 3'b011 || in_funct3 == 3'b110))
            || (in_funct3[1:0] == 2'b01 && in_addr[0])
            || (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00)
            || (in_funct3[1:0] == 2'b11 && in_addr[2:0] != 3'b000);
    end

    assign cnt_nxt = {1'b0, cnt} + (CNT_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        store_q  <= in_store;
                        funct3_q <= in_funct3;
                        off_q    <= in_off;
                        addr_q   <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        wdata_q  <= in_wdata << {in_off, 3'b000};
                        wstrb_q  <= in_wstrb;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        mis_q    <= bad;
                        state    <= bad ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    cnt <= cnt_nxt[CNT_W-1:0];
                    // A response in the same cycle as the timeout takes priority
                    if (mem_rsp_valid) begin
                        rdata_q <= mem_rsp_rdata;
                        err_q   <= mem_rsp_err;
                        state   <= DONE;
                    end else if (TIMEOUT != 0 && cnt_nxt == TO_V) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = store_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign out_valid     = (state == DONE);
    assign out_misalign  = out_valid & mis_q;
    assign out_buserr    = out_valid & err_q;

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] ext;
    logic            sgn;

    always_comb begin
        sh   = rdata_q >> {off_q, 3'b000};
        keep = '1;
        sgn  = 1'b0;
        case (funct3_q)
            3'b000: begin keep = XLEN'(8'hFF);         sgn = sh[7];  end
            3'b001: begin keep = XLEN'(16'hFFFF);      sgn = sh[15]; end
            3'b010: begin keep = XLEN'(32'hFFFF_FFFF); sgn = sh[31]; end
            3'b100: keep = XLEN'(8'hFF);
            3'b101: keep = XLEN'(16'hFFFF);
            3'b110: keep = XLEN'(32'hFFFF_FFFF);
            default: keep = '1;
        endcase
        ext = (sh & keep) | ({XLEN{sgn}} & ~keep);
    end

    assign out_rdata = (out_valid && !store_q && !mis_q && !err_q) ? ext : '0;

endmodule

// File: tb/tb_lsu_mc.sv
// tb/tb_lsu_mc.sv - self-checking bench for lsu_mc at XLEN=32 (TIMEOUT=4) and XLEN=64
module tb_lsu_mc;
    localparam int TO32 = 4;

    typedef struct {
        bit          is64;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        bit          err;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] e_addr;
        logic [7:0]  e_wstrb;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        bit          e_mis;
        bit          e_bus;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_store = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_addr = '0;
    logic [63:0] in_wdata = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_rdata = '0;
    logic        mem_rsp_err = 1'b0;

    logic        a_in_ready, a_req_valid, a_req_wen, a_out_valid, a_mis, a_bus;
    logic [31:0] a_req_addr, a_req_wdata, a_out_rdata;
    logic [3:0]  a_req_wstrb;
    logic        b_in_ready, b_req_valid, b_req_wen, b_out_valid, b_mis, b_bus;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_out_rdata;
    logic [7:0]  b_req_wstrb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_mc #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO32)) u32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
        .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(a_req_addr),
        .mem_req_wen(a_req_wen), .mem_req_wdata(a_req_wdata), .mem_req_wstrb(a_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata[31:0]), .mem_rsp_err(mem_rsp_err),
        .out_valid(a_out_valid), .out_rdata(a_out_rdata), .out_misalign(a_mis), .out_buserr(a_bus)
    );

    lsu_mc #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(b_req_addr),
        .mem_req_wen(b_req_wen), .mem_req_wdata(b_req_wdata), .mem_req_wstrb(b_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .out_valid(b_out_valid), .out_rdata(b_out_rdata), .out_misalign(b_mis), .out_buserr(b_bus)
    );

    wire        in_ready  = sel ? b_in_ready  : a_in_ready;
    wire        req_valid = sel ? b_req_valid : a_req_valid;
    wire [31:0] req_addr  = sel ? b_req_addr  : a_req_addr;
    wire        req_wen   = sel ? b_req_wen   : a_req_wen;
    wire [63:0] req_wdata = sel ? b_req_wdata : {32'b0, a_req_wdata};
    wire [7:0]  req_wstrb = sel ? b_req_wstrb : {4'b0, a_req_wstrb};
    wire        out_valid = sel ? b_out_valid : a_out_valid;
    wire [63:0] out_rdata = sel ? b_out_rdata : {32'b0, a_out_rdata};
    wire        out_mis   = sel ? b_mis : a_mis;
    wire        out_bus   = sel ? b_bus : a_bus;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit is64, input bit st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input bit err, input int rdy, input int rsp,
                                input logic [31:0] ea, input logic [7:0] ew, input logic [63:0] ewd,
                                input logic [63:0] erd, input bit emis, input bit ebus);
        vec_t v;
        v.is64 = is64; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.rdy_dly = rdy; v.rsp_dly = rsp;
        v.e_addr = ea; v.e_wstrb = ew; v.e_wdata = ewd; v.e_rdata = erd; v.e_mis = emis; v.e_bus = ebus;
        return v;
    endfunction

    function automatic bit timed_out(input vec_t v);
        return !v.is64 && (v.rsp_dly < 0 || v.rsp_dly >= TO32);
    endfunction

    // Reference: sizes in bytes, offsets as address modulo word bytes, extension by arithmetic masks
    function automatic vec_t model(input vec_t v);
        int nb;
        int sz;
        int off;
        longint unsigned xm;
        longint unsigned fm;
        longint unsigned field;
        vec_t r;
        r = v;
        nb = v.is64 ? 8 : 4;
        sz = 1 << v.f3[1:0];
        off = int'(v.addr % nb);
        xm = v.is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        r.e_mis = (v.f3 == 3'b111) || (!v.is64 && (v.f3 == 3'b011 || v.f3 == 3'b110))
                  || (v.addr % sz != 0);
        r.e_addr = v.addr & ~32'(nb - 1);
        r.e_wstrb = 8'(((1 << sz) - 1) << off);
        r.e_wdata = (v.wdata << (8 * off)) & xm;
        r.e_bus = !r.e_mis && (timed_out(v) || v.err);
        if (r.e_mis || v.st || r.e_bus) begin
            r.e_rdata = '0;
        end else begin
            fm = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 1);
            field = ((v.rdata & xm) >> (8 * off)) & fm;
            if (!v.f3[2] && sz < nb && field[8 * sz - 1]) field = field | ~fm;
            r.e_rdata = field & xm;
        end
        return r;
    endfunction

    task automatic do_op(input vec_t v);
        int done_at;
        @(negedge clk);
        sel = v.is64; in_valid = 1'b1; in_store = v.st; in_funct3 = v.f3;
        in_addr = v.addr; in_wdata = v.wdata;
        chk("accept_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_store = ~v.st; in_funct3 = ~v.f3; in_addr = ~v.addr; in_wdata = ~v.wdata;
        if (v.e_mis) begin
            chk("mis_out_valid", out_valid, 1);
            chk("mis_flag", out_mis, 1);
            chk("mis_buserr", out_bus, 0);
            chk("mis_rdata", out_rdata, 0);
            chk("mis_no_req", req_valid, 0);
        end else begin
            for (int d = 0; d <= v.rdy_dly; d++) begin
                chk("req_valid", req_valid, 1);
                chk("req_addr", req_addr, v.e_addr);
                chk("req_wen", req_wen, v.st);
                chk("req_wstrb", req_wstrb, v.e_wstrb);
                chk("req_wdata", req_wdata, v.e_wdata);
                chk("req_out_valid", out_valid, 0);
                mem_req_ready = (d == v.rdy_dly);
                mem_rsp_valid = 1'b1; mem_rsp_rdata = ~v.rdata; mem_rsp_err = 1'b1;
                @(negedge clk);
            end
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
            done_at = timed_out(v) ? TO32 - 1 : v.rsp_dly;
            for (int d = 0; d <= done_at; d++) begin
                chk("wait_req_valid", req_valid, 0);
                chk("wait_out_valid", out_valid, 0);
                if (d == v.rsp_dly) begin
                    mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rdata; mem_rsp_err = v.err;
                end
                @(negedge clk);
                mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
            end
            chk("done_out_valid", out_valid, 1);
            chk("done_rdata", out_rdata, v.e_rdata);
            chk("done_buserr", out_bus, v.e_bus);
            chk("done_misalign", out_mis, 0);
        end
        @(negedge clk);
        chk("post_out_valid", out_valid, 0);
        chk("post_flags", {out_mis, out_bus}, 0);
        chk("post_rdata", out_rdata, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_req_valid", req_valid, 0);
    endtask

    vec_t tbl[16];
    vec_t rv;

    initial begin
        tbl[0]  = mk(0, 0, 3'b000, 32'h8000_0003, 64'h0, 64'h80FF_1234, 0, 0, 0,
                     32'h8000_0000, 8'h08, 64'h0, 64'hFFFF_FF80, 0, 0);
        tbl[1]  = mk(0, 1, 3'b001, 32'h8000_0002, 64'h0000_ABCD, 64'hDEAD_BEEF, 0, 0, 0,
                     32'h8000_0000, 8'h0C, 64'hABCD_0000, 64'h0, 0, 0);
        tbl[2]  = mk(0, 0, 3'b010, 32'h8000_0001, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 3'b001, 32'h8000_0006, 64'h0, 64'h1234_5678, 1, 5, 1,
                     32'h8000_0004, 8'h0C, 64'h0, 64'h0, 0, 1);
        tbl[4]  = mk(0, 0, 3'b010, 32'h0000_0100, 64'h5555, 64'h0, 0, 0, -1,
                     32'h0000_0100, 8'h0F, 64'h5555, 64'h0, 0, 1);
        tbl[5]  = mk(0, 0, 3'b010, 32'h0000_0010, 64'h0, 64'h8765_4321, 0, 1, 3,
                     32'h0000_0010, 8'h0F, 64'h0, 64'h8765_4321, 0, 0);
        tbl[6]  = mk(0, 0, 3'b101, 32'h0000_0002, 64'h0, 64'h80FF_1234, 0, 0, 2,
                     32'h0, 8'h0C, 64'h0, 64'h80FF, 0, 0);
        tbl[7]  = mk(0, 0, 3'b100, 32'h0000_0001, 64'h0, 64'h80FF_1234, 0, 2, 0,
                     32'h0, 8'h02, 64'h0, 64'h12, 0, 0);
        tbl[8]  = mk(0, 0, 3'b011, 32'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 0, 3'b111, 32'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[10] = mk(1, 0, 3'b110, 32'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 0,
                     32'h8000_0000, 8'hF0, 64'h0, 64'h0000_0000_8765_4321, 0, 0);
        tbl[11] = mk(1, 0, 3'b010, 32'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 0,
                     32'h8000_0000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321, 0, 0);
        tbl[12] = mk(1, 0, 3'b011, 32'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 1,
                     32'h8000_0008, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0);
        tbl[13] = mk(1, 1, 3'b000, 32'h0000_0005, 64'hAB, 64'hFFFF, 0, 0, 0,
                     32'h0, 8'h20, 64'h0000_AB00_0000_0000, 64'h0, 0, 0);
        tbl[14] = mk(1, 1, 3'b011, 32'h0000_0004, 64'h1, 64'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[15] = mk(1, 0, 3'b000, 32'h0000_0007, 64'h0, 64'h7F00_0000_0000_0000, 0, 0, 0,
                     32'h0, 8'h80, 64'h0, 64'h7F, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_in_ready32", a_in_ready, 1);
        chk("rst_in_ready64", b_in_ready, 1);
        chk("rst_req_valid", {a_req_valid, b_req_valid}, 0);
        chk("rst_out_valid", {a_out_valid, b_out_valid}, 0);
        chk("rst_flags", {a_mis, a_bus, b_mis, b_bus}, 0);
        chk("rst_rdata", {a_out_rdata, b_out_rdata}, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) do_op(tbl[i]);

        // Reset while waiting for a response, then a stray response in IDLE
        @(negedge clk);
        sel = 1'b0; in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h40;
        @(negedge clk);
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rstw_in_wait", req_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_in_ready", in_ready, 1);
        chk("rstw_req_valid", req_valid, 0);
        chk("rstw_out_valid", out_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1234;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stray_out_valid", out_valid, 0);
        chk("stray_in_ready", in_ready, 1);
        repeat (TO32 + 1) @(negedge clk);
        chk("stray_late_out_valid", out_valid, 0);

        // Reset while the request is still being presented
        sel = 1'b1; in_valid = 1'b1; in_store = 1'b1; in_funct3 = 3'b011; in_addr = 32'h80;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstr_req_valid_before", req_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstr_req_valid_after", req_valid, 0);
        chk("rstr_in_ready", in_ready, 1);

        for (int i = 0; i < 300; i++) begin
            rv.is64 = 1'($urandom_range(0, 1));
            rv.st = 1'($urandom_range(0, 1));
            rv.f3 = 3'($urandom_range(0, 7));
            rv.addr = $urandom;
            if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~32'((1 << rv.f3[1:0]) - 1);
            rv.wdata = {$urandom, $urandom};
            rv.rdata = {$urandom, $urandom};
            rv.err = ($urandom_range(0, 7) == 0);
            rv.rdy_dly = $urandom_range(0, 3);
            rv.rsp_dly = $urandom_range(0, 4);
            do_op(model(rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
